// File: rtl/cop_pkg.sv
// Shared definitions for the PCPI-to-coprocessor bridge: custom opcodes,
// FSM state encoding and the opcode decode helper.
package cop_pkg;

  localparam logic [6:0] CUSTOM_0 = 7'h0B;
  localparam logic [6:0] CUSTOM_1 = 7'h2B;
  localparam logic [6:0] CUSTOM_2 = 7'h5B;
  localparam logic [6:0] CUSTOM_3 = 7'h7B;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_EXEC    = 3'd1,
    ST_RESP    = 3'd2,
    ST_RELEASE = 3'd3,
    ST_NACK    = 3'd4
  } state_t;

  function automatic logic is_custom(input logic [6:0] opcode);
    return (opcode == CUSTOM_0) || (opcode == CUSTOM_1) ||
           (opcode == CUSTOM_2) || (opcode == CUSTOM_3);
  endfunction

endpackage

// File: rtl/cop_pcpi_bridge.sv
// Registers PCPI requests for the combinational coprocessor, runs its
// valid/rdywr handshake and returns the result as a one-cycle ready pulse.
module cop_pcpi_bridge
  import cop_pkg::*;
#(
  parameter int TIMEOUT = 8
) (
  input  logic        cop_clk,
  input  logic        cop_rst,
  input  logic        pcpi_valid,
  input  logic [31:0] pcpi_insn,
  input  logic [31:0] pcpi_rs1,
  input  logic [31:0] pcpi_rs2,
  output logic        pcpi_wr,
  output logic [31:0] pcpi_rd,
  output logic        pcpi_wait,
  output logic        pcpi_ready,
  output logic        cop_valid,
  output logic        cop_rdywr,
  input  logic        cop_ready,
  input  logic        cop_wait,
  input  logic        cop_wr,
  output logic [31:0] cop_insn,
  output logic [31:0] cop_rs1,
  output logic [31:0] cop_rs2,
  input  logic [31:0] cop_rd
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT);

  state_t        state_reg, state_next;
  logic [TW-1:0] timer_reg, timer_next;
  logic [31:0]   insn_reg, rs1_reg, rs2_reg, result_reg;
  logic          capture, load_result;

  always_comb begin
    state_next  = state_reg;
    timer_next  = timer_reg;
    capture     = 1'b0;
    load_result = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (pcpi_valid && is_custom(pcpi_insn[6:0])) begin
          capture    = 1'b1;
          timer_next = '0;
          state_next = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (!pcpi_valid) begin
          state_next = ST_IDLE;
        end else if (cop_wr && cop_ready) begin
          load_result = 1'b1;
          state_next  = ST_RESP;
        end else if (cop_wait) begin
          // Saturating count so the timer can never wrap back below TIMEOUT.
          if (timer_reg != TIMER_MAX) timer_next = timer_reg + 1'b1;
          if (timer_next == TIMER_MAX) state_next = ST_NACK;
        end else if (!cop_wr) begin
          state_next = ST_NACK;
        end
        // cop_wr with cop_ready low is a stall: hold state and timer.
      end
      ST_RESP: state_next = ST_RELEASE;
      ST_RELEASE, ST_NACK: begin
        // Wait for the core to drop its request so it is not re-issued.
        if (!pcpi_valid) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge cop_clk) begin
    if (cop_rst) begin
      state_reg  <= ST_IDLE;
      timer_reg  <= '0;
      insn_reg   <= '0;
      rs1_reg    <= '0;
      rs2_reg    <= '0;
      result_reg <= '0;
    end else begin
      state_reg <= state_next;
      timer_reg <= timer_next;
      if (capture) begin
        insn_reg <= pcpi_insn;
        rs1_reg  <= pcpi_rs1;
        rs2_reg  <= pcpi_rs2;
      end
      if (load_result) result_reg <= cop_rd;
    end
  end

  assign cop_valid  = (state_reg == ST_EXEC);
  assign cop_rdywr  = (state_reg == ST_EXEC);
  assign pcpi_wait  = (state_reg == ST_EXEC);
  assign pcpi_ready = (state_reg == ST_RESP);
  assign pcpi_wr    = (state_reg == ST_RESP);
  assign pcpi_rd    = (state_reg == ST_RESP) ? result_reg : 32'd0;
  assign cop_insn   = insn_reg;
  assign cop_rs1    = rs1_reg;
  assign cop_rs2    = rs2_reg;

endmodule

// File: doc/cop_pcpi_bridge.md
# cop_pcpi_bridge

Sequential bridge between the core's PCPI port and the combinational Alzette/ELL/rotate coprocessor. It accepts custom-opcode instructions from the core and registers the instruction and operands. It drives the coprocessor's valid/rdywr handshake, captures the result, and returns it to the core as a one-cycle ready/write pulse. It supplies the operand register stage that removes the register-file-to-ALU combinational path through the coprocessor.

## Interface
Parameters:
- `TIMEOUT`, default 8: maximum EXEC cycles with `cop_wait` high before the bridge abandons the instruction.

Ports:
- `cop_clk` in 1: clock. One clock; all state is updated on the rising edge.
- `cop_rst` in 1: synchronous reset, active-high.
- `pcpi_valid` in 1: core request valid.
- `pcpi_insn` in 32: instruction word.
- `pcpi_rs1` in 32: operand 1.
- `pcpi_rs2` in 32: operand 2.
- `pcpi_wr` out 1: write `pcpi_rd` to rd.
- `pcpi_rd` out 32: result.
- `pcpi_wait` out 1: core must keep waiting.
- `pcpi_ready` out 1: instruction complete.
- `cop_valid` out 1: request to coprocessor.
- `cop_rdywr` out 1: bridge can accept writeback.
- `cop_ready` in 1: coprocessor not stalled.
- `cop_wait` in 1: coprocessor multi-cycle busy.
- `cop_wr` in 1: coprocessor claims the instruction and has a result.
- `cop_insn` out 32: registered instruction.
- `cop_rs1` out 32: registered operand 1.
- `cop_rs2` out 32: registered operand 2.
- `cop_rd` in 32: coprocessor result.

## Operation
The FSM has five states: IDLE, EXEC, RESP, RELEASE and NACK.

- **IDLE**
  - If `pcpi_valid` is high and `pcpi_insn[6:0]` is one of 0x0B, 0x2B, 0x5B or 0x7B, latch insn/rs1/rs2 and go to EXEC. The timer is cleared.
  - Other opcodes are ignored and the bridge stays in IDLE.
- **EXEC**
  - Outputs: `cop_valid`=1, `cop_rdywr`=1, `pcpi_wait`=1.
  - Transitions, in priority order:
    1. `pcpi_valid`=0: core abort. Go to IDLE, no response.
    2. `cop_wr & cop_ready`: capture `cop_rd` into the result register and go to RESP.
    3. `cop_wait`=1: increment the timer. When the timer reaches `TIMEOUT`, go to NACK.
    4. Otherwise (`cop_wr`=0 and `cop_wait`=0): the instruction is unclaimed. Go to NACK.
  - `cop_wr & ~cop_ready` means the coprocessor is stalled. The bridge stays in EXEC and does not advance the timer.
- **RESP**
  - Outputs: `pcpi_ready`=1, `pcpi_wr`=1, `pcpi_rd`=result, for exactly one cycle.
  - Always go to RELEASE.
- **RELEASE / NACK**
  - All outputs are 0; `pcpi_wait`=0.
  - Go to IDLE in the first cycle `pcpi_valid`=0. This prevents re-issuing a still-asserted request.
  - In NACK the core's own PCPI timeout raises the illegal-instruction trap.
- `cop_insn`, `cop_rs1` and `cop_rs2` always reflect the latched registers. They change only on the IDLE-to-EXEC capture.
- `pcpi_rd` is 0 outside RESP. The result register holds its value until the next capture.

## Timing
- Reset values: state=IDLE, all registers 0. Every output is 0, including `pcpi_rd`, `cop_insn`, `cop_rs1` and `cop_rs2`.
- Reset mid-operation forces IDLE on the next edge. No `pcpi_ready` pulse is emitted.
- Latency with a combinational coprocessor:
  - Cycle 0: `pcpi_valid` sampled in IDLE.
  - Cycle 1: EXEC, `cop_valid`=1, `cop_wr` sampled.
  - Cycle 2: `pcpi_ready` pulse.
  - Total: 2 cycles from accept to ready.
- Each `cop_wait` cycle adds one cycle of latency, up to `TIMEOUT`.
- `pcpi_wait` is asserted one cycle after `pcpi_valid`. This is within the core's 16-cycle PCPI timeout.
- Simultaneous `cop_wr & cop_ready` and timer expiry: the result wins and the bridge goes to RESP.
- Timer width is clog2(`TIMEOUT`+1). The timer saturates and never wraps.
- Throughput: at most one instruction per 4 cycles (IDLE, EXEC, RESP, RELEASE).

## Structure
- Shared package `cop_pkg`:
  - Opcode localparams `CUSTOM_0` through `CUSTOM_3`.
  - The 3-bit state encoding (IDLE=0, EXEC=1, RESP=2, RELEASE=3, NACK=4).
  - An `is_custom(opcode)` function.
- The block is flat with no sub-modules. It is instantiated in the SoC top between the core PCPI port and `cop_ise`.

## Test plan
- **Normal completion.** IDLE. Drive `pcpi_valid`=1, insn=0x1000000B, rs1=0x12345678. The coprocessor model drives `cop_wr`=1 and `cop_rd`=0x78123456 in EXEC. Required: `pcpi_ready` and `pcpi_wr` high for exactly one cycle, 2 cycles after accept, with `pcpi_rd`=0x78123456.
- **Non-custom opcode.** insn=0x00000033 with `pcpi_valid` held 20 cycles. Required: `cop_valid`, `pcpi_wait` and `pcpi_ready` stay 0 throughout.
- **Unclaimed custom opcode.** insn 0x0000007B; the model keeps `cop_wr`=0 and `cop_wait`=0. Required: one EXEC cycle, then NACK; no `pcpi_ready`. The bridge returns to IDLE one cycle after `pcpi_valid` falls.
- **Wait and stall, then timeout.**
  - `cop_wait`=1 for 3 cycles, then `cop_wr`=1 with `cop_ready`=0 for 2 cycles, then `cop_ready`=1 with `cop_rd`=0xDEADBEEF. Required: `pcpi_ready` at cycle 7 with `pcpi_rd`=0xDEADBEEF.
  - Repeat with `cop_wait` held high. Required: NACK after 8 wait cycles.
- **Core abort and reset.** Drop `pcpi_valid` in EXEC. Required: IDLE next cycle, no response. Separately, assert `cop_rst` in EXEC. Required: all outputs 0 on the next edge.
- **Back-to-back requests.** Issue a second request while the first `pcpi_valid` is still high after ready. Required: no re-issue; the second request completes only after `pcpi_valid` has been low for at least 1 cycle.
